ifetch_seq: RTL
===============

IFETCH_SEQ -- requirements
Module: ifetch_seq

Interface
- REQ-001: Parameter ADDR_W, default 16, memory address width.
- REQ-002: Parameter DATA_W, default 16, memory word width.
- REQ-003: Parameter WORDS, default 2, legal range 1..4, instruction words fetched per instruction.
- REQ-004: Parameter MFC_TIMEOUT, default 15, maximum WAIT cycles before error; only used with IFETCH_TIMEOUT_EN.
- REQ-005: Port clk, input, 1, clock; all state changes on rising edge.
- REQ-006: Port rst, input, 1, reset; asynchronous, active-high.
- REQ-007: Port start, input, 1, request one instruction fetch; sampled in IDLE only.
- REQ-008: Port flush, input, 1, synchronous abort of any fetch in progress.
- REQ-009: Port pc_in, input, ADDR_W, address of the first instruction word.
- REQ-010: Port mem_addr, output, ADDR_W, current word address (MAR).
- REQ-011: Port mem_en, output, 1, memory enable.
- REQ-012: Port mem_rw, output, 1, 1 = read; always read when mem_en = 1.
- REQ-013: Port mem_rdata, input, DATA_W, read data, valid while mem_mfc = 1.
- REQ-014: Port mem_mfc, input, 1, memory function complete.
- REQ-015: Port ir_out, output, WORDS*DATA_W, instruction register; word 0 in LSBs.
- REQ-016: Port ir_valid, output, 1, one-cycle pulse when ir_out has been updated.
- REQ-017: Port pc_next, output, ADDR_W, address following the last word fetched.
- REQ-018: Port pc_load, output, 1, one-cycle strobe for the PC to load pc_next; coincides with ir_valid.
- REQ-019: Port busy, output, 1, high in every state except IDLE.
- REQ-020: Port fetch_err, output, 1, one-cycle pulse on timeout.

Function
- REQ-021: States are IDLE, ADDR, REQ, WAIT, CAPT, DONE and ERR; all outputs are Moore-decoded from state and registers.
- REQ-022: In IDLE with start = 1 and flush = 0: latch pc_in into MAR, clear word count to 0, go to ADDR.
- REQ-023: ADDR: mem_addr = MAR, mem_en = 0; go to REQ.
- REQ-024: REQ: mem_en = 1, mem_rw = 1; go to WAIT.
- REQ-025: WAIT: mem_en = 1, mem_rw = 1.
  - mem_mfc = 1: capture mem_rdata into shadow slot[count], go to CAPT.
  - mem_mfc = 0: remain in WAIT.
- REQ-026: CAPT, count = WORDS-1: go to DONE.
  - Otherwise: MAR = MAR+1 (mod 2^ADDR_W), count = count+1, go to REQ.
- REQ-027: DONE:
  - Copy the shadow to ir_out.
  - ir_valid = 1, pc_load = 1, pc_next = MAR+1 (mod 2^ADDR_W).
  - Go to IDLE.
- REQ-028: ir_out changes only on entry to DONE; an aborted or failed fetch leaves ir_out unchanged.
- REQ-029: Latency with WORDS = 1 and mem_mfc high in the first WAIT cycle: ir_valid is high 5 cycles after the start edge.
  - Each extra word adds 3 cycles.
  - Each extra WAIT cycle adds 1 cycle.
- REQ-030: start is ignored outside IDLE.
- REQ-031: flush = 1 in any state forces IDLE at the next edge; no ir_valid, pc_load or fetch_err is produced.
  - flush takes priority over start, mem_mfc and timeout.
- REQ-032: Address wrap: MAR = 2^ADDR_W-1 increments to 0 with no error.
- REQ-033: A mem_mfc pulse outside WAIT is ignored.

Reset
- REQ-034: rst = 1 immediately forces IDLE, including mid-fetch.
  - MAR, count, shadow, ir_out, pc_next and timeout counter reset to 0.
  - mem_en, mem_rw, ir_valid, pc_load, busy and fetch_err reset to 0.
- REQ-035: The first start is accepted on the first clk edge after rst falls.

Configuration
- REQ-036: With IFETCH_TIMEOUT_EN defined:
  - A counter clears on WAIT entry and increments each WAIT cycle with mem_mfc = 0.
  - On reaching MFC_TIMEOUT, go to ERR.
  - ERR: fetch_err = 1 for one cycle, then go to IDLE.
- REQ-037: Without IFETCH_TIMEOUT_EN, WAIT waits indefinitely, ERR is unreachable and fetch_err is tied to 0.

Structure
- REQ-038: Package ifetch_pkg holds the state enumeration and the default parameter constants.
- REQ-039: The timeout counter is sub-module ifetch_wdt (clear, enable, limit, expired); it is instantiated only under IFETCH_TIMEOUT_EN.

Verification
- REQ-040: WORDS = 1, pc_in = 0x0040, mem_mfc high in the first WAIT cycle, mem_rdata = 0xA5A5.
  - Expect ir_out = 0xA5A5, ir_valid 5 cycles after start, pc_next = 0x0041.
- REQ-041: WORDS = 2, pc_in = 0x0100, words 0x1111 and 0x2222, 2 wait cycles each.
  - Expect mem_addr 0x0100 then 0x0101, ir_out = 0x22221111, pc_next = 0x0102, ir_valid at cycle 12.
- REQ-042: WORDS = 2, pc_in = 0xFFFF.
  - Expect second word read from 0x0000, pc_next = 0x0001.
- REQ-043: flush asserted in WAIT of the second word.
  - Expect IDLE next cycle, ir_out unchanged, no ir_valid; a following start fetches correctly.
- REQ-044: IFETCH_TIMEOUT_EN, MFC_TIMEOUT = 15, mem_mfc held low.
  - Expect fetch_err pulse after 15 WAIT cycles, then IDLE, ir_out unchanged.
- REQ-045: rst asserted mid-WAIT and start held high during busy.
  - Expect all outputs 0 immediately; start is ignored while busy.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding and default parameters for the instruction
// fetch sequencer (ifetch_seq) and its memory-bus interface.
package ifetch_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 16;
    localparam int WORDS_DEF       = 2;
    localparam int MFC_TIMEOUT_DEF = 15;

    // state  | meaning
    // S_IDLE | waiting for start
    // S_ADDR | MAR presented on mem_addr, memory not yet enabled
    // S_REQ  | read request issued
    // S_WAIT | read outstanding, waiting for mem_mfc
    // S_CAPT | word captured into shadow slot; next word or finish
    // S_DONE | shadow copied to ir_out, ir_valid/pc_load strobed
    // S_ERR  | timeout reported via fetch_err
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

endpackage

// File: rtl/ifetch_seq_if.sv
// ifetch_seq_if: memory bus between the fetch sequencer (master) and the
// instruction memory (slave). mem_rdata is only meaningful while mem_mfc = 1.
interface ifetch_seq_if
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_mfc;

    modport master (
        output mem_addr,
        output mem_en,
        output mem_rw,
        input  mem_rdata,
        input  mem_mfc
    );

    modport slave (
        input  mem_addr,
        input  mem_en,
        input  mem_rw,
        output mem_rdata,
        output mem_mfc
    );

endinterface

// File: rtl/ifetch_wdt.sv
// ifetch_wdt: down-counting watchdog for the WAIT state. clear reloads the
// limit; each enabled cycle counts down; expired flags the enabled cycle that
// would be the limit-th one, so the caller can leave WAIT at that edge.
module ifetch_wdt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on clear, otherwise count down while enabled and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = limit;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expired = enable && !clear && (cnt_q == CNT_W'(1));

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: fetches WORDS consecutive memory words starting at pc_in into a
// shadow register, then publishes them on ir_out together with ir_valid,
// pc_load and pc_next. flush aborts at the next edge without touching ir_out.
// Optional build macro IFETCH_TIMEOUT_EN adds a WAIT watchdog (MFC_TIMEOUT
// cycles) that reports fetch_err and returns to IDLE.
module ifetch_seq
    import ifetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WORDS       = WORDS_DEF,
    parameter int MFC_TIMEOUT = MFC_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [ADDR_W-1:0]       pc_in,
    ifetch_seq_if.master            mem,
    output logic [WORDS*DATA_W-1:0] ir_out,
    output logic                    ir_valid,
    output logic [ADDR_W-1:0]       pc_next,
    output logic                    pc_load,
    output logic                    busy,
    output logic                    fetch_err
);

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    if (WORDS < 1 || WORDS > 4) begin : g_bad_words
        $error("ifetch_seq: WORDS must be within 1..4");
    end
    if (MFC_TIMEOUT < 1) begin : g_bad_timeout
        $error("ifetch_seq: MFC_TIMEOUT must be at least 1");
    end

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       mar_q, mar_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORDS*DATA_W-1:0] shadow_q, shadow_d;
    logic [WORDS*DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]       pc_next_q, pc_next_d;
    logic                    mem_en_q, mem_en_d;
    logic                    ir_valid_q, ir_valid_d;
    logic                    busy_q, busy_d;
    logic                    wdt_expired;

    // Next-state, MAR, word count and shadow capture; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mar_d   = pc_in;
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (mem.mem_mfc) begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shadow_d[i*DATA_W +: DATA_W] = mem.mem_rdata;
                            end
                        end
                        state_d = S_CAPT;
                    end else if (wdt_expired) begin
                        state_d = S_ERR;
                    end
                end
                S_CAPT: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        mar_d   = mar_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs registered from the next state so they line up with state_q.
    always_comb begin
        ir_d       = ir_q;
        pc_next_d  = pc_next_q;
        mem_en_d   = (state_d == S_REQ) || (state_d == S_WAIT);
        busy_d     = (state_d != S_IDLE);
        ir_valid_d = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            ir_d      = shadow_q;
            pc_next_d = mar_q + 1'b1;
        end
    end

    // FSM state, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mar_q      <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            ir_q       <= '0;
            pc_next_q  <= '0;
            mem_en_q   <= 1'b0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            ir_q       <= ir_d;
            pc_next_q  <= pc_next_d;
            mem_en_q   <= mem_en_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Every enabled access is a read, so mem_rw simply follows mem_en.
    assign mem.mem_addr = mar_q;
    assign mem.mem_en   = mem_en_q;
    assign mem.mem_rw   = mem_en_q;
    assign ir_out       = ir_q;
    assign ir_valid     = ir_valid_q;
    assign pc_load      = ir_valid_q;
    assign pc_next      = pc_next_q;
    assign busy         = busy_q;

`ifdef IFETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(MFC_TIMEOUT + 1);

    logic fetch_err_q;
    logic fetch_err_d;

    assign fetch_err_d = (state_d == S_ERR);

    // fetch_err marks the single ERR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;

    ifetch_wdt #(
        .CNT_W (TMO_W)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != S_WAIT),
        .enable  ((state_q == S_WAIT) && !mem.mem_mfc),
        .limit   (TMO_W'(MFC_TIMEOUT)),
        .expired (wdt_expired)
    );
`else
    assign wdt_expired = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule
